// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared step layout, beat counts and FSM state for the trace-step path
package trace_pkg;

  localparam int STEP_W        = 560;
  localparam int BEAT_W        = 32;
  localparam int REG_W         = 32;
  localparam int INSTR_W       = 96;
  localparam int HINT_W        = 72;
  localparam int NUM_REGS      = 10;
  localparam int INSTR_MSB     = 559;
  localparam int REGS_MSB      = 463;
  localparam int HINT1_MSB     = 143;
  localparam int HINT2_MSB     = 71;
  localparam int BEATS_PAYLOAD = 18;

  // Register order inside the step, most significant first.
  typedef enum logic [3:0] {
    REG_EAX, REG_EBX, REG_ECX, REG_EDX, REG_ESI,
    REG_EDI, REG_ESP, REG_EBP, REG_EIP, REG_EFLAGS
  } reg_idx_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/step_pack.sv
// rtl/step_pack.sv - combinational packing of step fields into the 560-bit step vector
module step_pack
  import trace_pkg::*;
(
  input  logic [INSTR_W-1:0]             raw_instr_i,
  input  logic [NUM_REGS-1:0][REG_W-1:0] regs_i,
  input  logic [HINT_W-1:0]              raw_hint1_i,
  input  logic [HINT_W-1:0]              raw_hint2_i,
  output logic [STEP_W-1:0]              step_o
);

  always_comb begin
    step_o = '0;
    step_o[INSTR_MSB -: INSTR_W] = raw_instr_i;
    for (int i = 0; i < NUM_REGS; i++) begin
      step_o[REGS_MSB - REG_W*i -: REG_W] = regs_i[i];
    end
    step_o[HINT1_MSB -: HINT_W] = raw_hint1_i;
    step_o[HINT2_MSB -: HINT_W] = raw_hint2_i;
  end

endmodule

// File: rtl/trace_step_packer.sv
// rtl/trace_step_packer.sv - captures one step per handshake and streams it as 32-bit beats
module trace_step_packer
  import trace_pkg::*;
#(
  parameter bit HEADER_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [95:0]   raw_instr,
  input  logic [31:0]   eax,
  input  logic [31:0]   ebx,
  input  logic [31:0]   ecx,
  input  logic [31:0]   edx,
  input  logic [31:0]   esi,
  input  logic [31:0]   edi,
  input  logic [31:0]   esp,
  input  logic [31:0]   ebp,
  input  logic [31:0]   eip,
  input  logic [31:0]   eflags,
  input  logic [71:0]   raw_hint1,
  input  logic [71:0]   raw_hint2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic          out_last,
  output logic [31:0]   seq_num
);

  localparam logic [4:0] CNT_MAX = HEADER_EN ? 5'(BEATS_PAYLOAD) : 5'(BEATS_PAYLOAD - 1);
  localparam int         EXT_W   = STEP_W + 16;

  state_e              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [STEP_W-1:0]   hold_q, hold_d, step_w;
  logic [BEAT_W-1:0]   hdr_q, hdr_d, seq_q, seq_d, data_q, data_d;
  logic                last_q, last_d;
  logic                capture;

  step_pack u_pack (
    .raw_instr_i (raw_instr),
    .regs_i      ({eflags, eip, ebp, esp, edi, esi, edx, ecx, ebx, eax}),
    .raw_hint1_i (raw_hint1),
    .raw_hint2_i (raw_hint2),
    .step_o      (step_w)
  );

  // The step is padded with 16 zero bits so the final beat is a plain 32-bit slice.
  function automatic logic [BEAT_W-1:0] beat_sel(input logic [STEP_W-1:0] s,
                                                 input logic [BEAT_W-1:0] h,
                                                 input logic [4:0]        c);
    logic [EXT_W-1:0] ext;
    int               k;
    k   = HEADER_EN ? int'(c) - 1 : int'(c);
    ext = {s, 16'h0000} << (BEAT_W * k);
    if (HEADER_EN && c == 5'd0) return h;
    return ext[EXT_W-1 -: BEAT_W];
  endfunction

  assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_SEND) & last_q & out_ready);
  assign capture  = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    hdr_d   = hdr_q;
    seq_d   = seq_q;
    if (state_q == ST_SEND && out_ready) begin
      if (last_q) begin
        state_d = ST_IDLE;
        cnt_d   = 5'd0;
      end else begin
        cnt_d   = cnt_q + 5'd1;
      end
    end
    if (capture) begin
      state_d = ST_SEND;
      cnt_d   = 5'd0;
      hold_d  = step_w;
      hdr_d   = seq_q;
      seq_d   = seq_q + 32'd1;
    end
    data_d = beat_sel(hold_d, hdr_d, cnt_d);
    last_d = (state_d == ST_SEND) && (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      hdr_q   <= '0;
      seq_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      hdr_q   <= hdr_d;
      seq_q   <= seq_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = (state_q == ST_SEND);
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign seq_num   = seq_q;

endmodule

// File: tb/tb_trace_step_packer.sv
// tb/tb_trace_step_packer.sv - directed self-checking bench for trace_step_packer
module tb_trace_step_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [95:0] raw_instr = '0;
  logic [31:0] eax = '0, ebx = '0, ecx = '0, edx = '0, esi = '0, edi = '0;
  logic [31:0] esp = '0, ebp = '0, eip = '0, eflags = '0;
  logic [71:0] raw_hint1 = '0, raw_hint2 = '0;

  logic in_ready_h, out_valid_h, out_last_h, in_ready_n, out_valid_n, out_last_n;
  logic [31:0] out_data_h, seq_num_h, out_data_n, seq_num_n;

  localparam logic [71:0] HINT_FIRST_VAL  = 72'h111111111111111111;
  localparam logic [71:0] HINT_SECOND_VAL = 72'h222222222222222222;

  int tests = 0, fails = 0;
  bit sel_n = 1'b0;
  int cy = 0, nacc = 0, inr_busy = 0;
  logic [31:0] bq[$];
  bit lq[$];
  int bcyc[$], acc_cyc[$];
  bit acc_last[$];
  bit prev_stall = 1'b0, prev_last;
  logic [31:0] prev_data;
  logic s_in_ready, s_valid, s_last;
  logic [31:0] s_data, s_seq;

  always #5 clk = ~clk;

  trace_step_packer #(.HEADER_EN(1'b1)) u_h (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_h), .raw_instr(raw_instr),
    .eax(eax), .ebx(ebx), .ecx(ecx), .edx(edx), .esi(esi), .edi(edi), .esp(esp), .ebp(ebp),
    .eip(eip), .eflags(eflags), .raw_hint1(raw_hint1), .raw_hint2(raw_hint2),
    .out_valid(out_valid_h), .out_ready(out_ready), .out_data(out_data_h),
    .out_last(out_last_h), .seq_num(seq_num_h));

  trace_step_packer #(.HEADER_EN(1'b0)) u_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n), .raw_instr(raw_instr),
    .eax(eax), .ebx(ebx), .ecx(ecx), .edx(edx), .esi(esi), .edi(edi), .esp(esp), .ebp(ebp),
    .eip(eip), .eflags(eflags), .raw_hint1(raw_hint1), .raw_hint2(raw_hint2),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n),
    .out_last(out_last_n), .seq_num(seq_num_n));

  function automatic logic [95:0] f_instr(int idx);
    return 96'h0102030405060708090A0B0C ^ 96'(idx);
  endfunction

  function automatic logic [31:0] f_reg(int r, int idx);
    if (r == 9) return 32'h00000202 + 32'(idx);
    return 32'hAAAA0001 + 32'(r) + 32'(idx << 12);
  endfunction

  function automatic logic [559:0] exp_step(int idx);
    return {f_instr(idx), f_reg(0, idx), f_reg(1, idx), f_reg(2, idx), f_reg(3, idx),
            f_reg(4, idx), f_reg(5, idx), f_reg(6, idx), f_reg(7, idx), f_reg(8, idx),
            f_reg(9, idx), HINT_FIRST_VAL, HINT_SECOND_VAL};
  endfunction

  function automatic logic [31:0] exp_beat(logic [559:0] st, int k);
    logic [575:0] t;
    t = {st, 16'h0000} >> (544 - 32 * k);
    return t[31:0];
  endfunction

  // Index of the first collected beat that disagrees with the reference stream, or -1.
  function automatic int first_bad(int nsteps, logic [31:0] hdr0);
    int b;
    logic [31:0] e;
    b = sel_n ? 18 : 19;
    for (int i = 0; i < nsteps * b; i++) begin
      if (!sel_n && (i % b) == 0) e = hdr0 + 32'(i / b);
      else e = exp_beat(exp_step(i / b), sel_n ? (i % b) : (i % b) - 1);
      if (i >= bq.size()) return i;
      if (bq[i] !== e || lq[i] !== ((i % b) == b - 1)) return i;
    end
    return -1;
  endfunction

  task automatic set_fields(int idx);
    raw_instr = f_instr(idx);
    eax = f_reg(0, idx); ebx = f_reg(1, idx); ecx = f_reg(2, idx); edx = f_reg(3, idx);
    esi = f_reg(4, idx); edi = f_reg(5, idx); esp = f_reg(6, idx); ebp = f_reg(7, idx);
    eip = f_reg(8, idx); eflags = f_reg(9, idx);
    raw_hint1 = HINT_FIRST_VAL; raw_hint2 = HINT_SECOND_VAL;
  endtask

  task automatic sample();
    s_in_ready = sel_n ? in_ready_n : in_ready_h;
    s_valid    = sel_n ? out_valid_n : out_valid_h;
    s_last     = sel_n ? out_last_n : out_last_h;
    s_data     = sel_n ? out_data_n : out_data_h;
    s_seq      = sel_n ? seq_num_n : seq_num_h;
  endtask

  task automatic tick(input bit iv, input bit ordy);
    @(negedge clk);
    set_fields(nacc);
    in_valid = iv;
    out_ready = ordy;
    #1;
    sample();
    if (prev_stall && s_valid) begin
      tests++;
      if (s_data !== prev_data || s_last !== prev_last) begin
        fails++;
        $display("FAIL stall_stable cyc=%0d got=%h/%b exp=%h/%b", cy, s_data, s_last, prev_data, prev_last);
      end
    end
    prev_stall = s_valid && !ordy;
    prev_data = s_data;
    prev_last = s_last;
    if (s_valid && ordy) begin
      bq.push_back(s_data); lq.push_back(s_last); bcyc.push_back(cy);
      if (s_in_ready) inr_busy++;
    end
    if (iv && s_in_ready) begin
      acc_cyc.push_back(cy); acc_last.push_back(s_last); nacc++;
    end
    cy++;
  endtask

  task automatic run(int nsteps, bit rnd, int budget, int target);
    int c = 0;
    while (bq.size() < target && c < budget) begin
      tick(nacc < nsteps, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      c++;
    end
    if (bq.size() < target) begin
      tests++; fails++;
      $display("FAIL run_timeout got=%0d beats exp=%0d", bq.size(), target);
    end
  endtask

  task automatic clr();
    bq.delete(); lq.delete(); bcyc.delete(); acc_cyc.delete(); acc_last.delete();
    nacc = 0; inr_busy = 0; prev_stall = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    prev_stall = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++;
    if ({out_valid_h, out_last_h, in_ready_h, seq_num_h, out_data_h} !== {3'b001, 64'h0}) begin
      fails++;
      $display("FAIL reset_hdr got=%b%b%b %h %h exp=001 0 0", out_valid_h, out_last_h, in_ready_h, seq_num_h, out_data_h);
    end
    tests++;
    if ({out_valid_n, out_last_n, in_ready_n, seq_num_n, out_data_n} !== {3'b001, 64'h0}) begin
      fails++;
      $display("FAIL reset_nohdr got=%b%b%b %h %h exp=001 0 0", out_valid_n, out_last_n, in_ready_n, seq_num_n, out_data_n);
    end
  endtask

  task automatic test_single();
    logic [31:0] exp_v[7] = '{32'h00000000, 32'h01020304, 32'h05060708, 32'hAAAA0001,
                              32'h00000202, 32'h11222222, 32'h22220000};
    int idx_v[7] = '{0, 1, 2, 4, 13, 16, 18};
    int nl = 0;
    do_reset(); clr();
    run(1, 1'b0, 40, 19);
    for (int i = 0; i < 7; i++) begin
      tests++;
      if (bq.size() <= idx_v[i] || bq[idx_v[i]] !== exp_v[i]) begin
        fails++;
        $display("FAIL single_beat%0d got=%h exp=%h", idx_v[i], bq.size() > idx_v[i] ? bq[idx_v[i]] : 32'hx, exp_v[i]);
      end
    end
    foreach (lq[i]) if (lq[i]) nl++;
    tests++;
    if (nl != 1 || lq.size() != 19 || !lq[18]) begin
      fails++; $display("FAIL single_last got=%0d lasts of %0d beats exp=1 at beat 18", nl, lq.size());
    end
    tests++;
    if (acc_cyc.size() != 1 || bcyc.size() == 0 || bcyc[0] - acc_cyc[0] != 1) begin
      fails++; $display("FAIL single_latency got=%0d accepts exp=1 accept and 1-cycle latency", acc_cyc.size());
    end
    tick(1'b0, 1'b0);
    tests++;
    if (s_seq !== 32'd1 || s_in_ready !== 1'b1 || s_valid !== 1'b0) begin
      fails++; $display("FAIL single_after got=seq %h rdy %b vld %b exp=seq 1 rdy 1 vld 0", s_seq, s_in_ready, s_valid);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    do_reset(); clr();
    run(3, 1'b0, 100, 57);
    bad = first_bad(3, 32'h0);
    tests++;
    if (bad != -1) begin
      fails++; $display("FAIL b2b_stream got=mismatch at beat %0d exp=none", bad);
    end
    tests++;
    if (acc_cyc.size() != 3 || acc_cyc[1] - acc_cyc[0] != 19 || acc_cyc[2] - acc_cyc[1] != 19
        || !acc_last[1] || !acc_last[2]) begin
      fails++; $display("FAIL b2b_accepts got=%0d accepts exp=3 spaced 19 on last beats", acc_cyc.size());
    end
    tests++;
    if (bcyc.size() != 57 || bcyc[56] - bcyc[0] != 56 || inr_busy != 3) begin
      fails++; $display("FAIL b2b_contig got=%0d beats, %0d busy readies exp=57 contiguous, 3", bcyc.size(), inr_busy);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    do_reset(); clr();
    run(3, 1'b1, 400, 57);
    bad = first_bad(3, 32'h0);
    tests++;
    if (bad != -1) begin
      fails++; $display("FAIL bp_stream got=mismatch at beat %0d exp=none", bad);
    end
    tick(1'b0, 1'b1);
    tests++;
    if (s_seq !== 32'd3) begin
      fails++; $display("FAIL bp_seq got=%h exp=00000003", s_seq);
    end
  endtask

  task automatic test_reset_mid();
    int bad, nl = 0;
    do_reset(); clr();
    run(1, 1'b0, 40, 8);
    foreach (lq[i]) if (lq[i]) nl++;
    rst = 1'b1; in_valid = 1'b1;
    @(negedge clk); #1;
    tests++;
    if (out_valid_h !== 1'b0 || out_last_h !== 1'b0 || seq_num_h !== 32'h0 || nl != 0) begin
      fails++; $display("FAIL midreset got=vld %b last %b seq %h lasts %0d exp=0 0 0 0", out_valid_h, out_last_h, seq_num_h, nl);
    end
    rst = 1'b0; in_valid = 1'b0;
    clr();
    run(1, 1'b0, 40, 19);
    bad = first_bad(1, 32'h0);
    tests++;
    if (bad != -1 || bq[0] !== 32'h0) begin
      fails++; $display("FAIL midreset_resend got=mismatch at beat %0d exp=none", bad);
    end
  endtask

  task automatic test_wrap();
    int bad;
    do_reset();
    @(negedge clk);
    force u_h.seq_d = 32'hFFFFFFFF;
    @(negedge clk);
    release u_h.seq_d;
    #1;
    tests++;
    if (seq_num_h !== 32'hFFFFFFFF) begin
      fails++; $display("FAIL wrap_preset got=%h exp=ffffffff", seq_num_h);
    end
    clr();
    run(2, 1'b0, 60, 38);
    bad = first_bad(2, 32'hFFFFFFFF);
    tests++;
    if (bad != -1 || bq[0] !== 32'hFFFFFFFF || bq[19] !== 32'h0) begin
      fails++; $display("FAIL wrap_headers got=%h,%h (bad %0d) exp=ffffffff,00000000", bq[0], bq[19], bad);
    end
    tick(1'b0, 1'b1);
    tests++;
    if (s_seq !== 32'd1) begin
      fails++; $display("FAIL wrap_seq got=%h exp=00000001", s_seq);
    end
  endtask

  task automatic test_no_header();
    logic [559:0] st;
    int bad;
    sel_n = 1'b1;
    do_reset(); clr();
    run(1, 1'b0, 40, 18);
    bad = first_bad(1, 32'h0);
    tests++;
    if (bad != -1 || bq[0] !== 32'h01020304 || bq[17] !== 32'h22220000) begin
      fails++; $display("FAIL nohdr_stream got=%h..%h (bad %0d) exp=01020304..22220000", bq[0], bq[17], bad);
    end
    st = '0;
    for (int i = 0; i < 17; i++) st[559 - 32*i -: 32] = bq[i];
    st[15:0] = bq[17][31:16];
    tests++;
    if (st[559:464] !== f_instr(0) || st[143:72] !== HINT_FIRST_VAL || st[71:0] !== HINT_SECOND_VAL) begin
      fails++; $display("FAIL nohdr_instr_hints got=%h exp=%h", st[559:464], f_instr(0));
    end
    for (int r = 0; r < 10; r++) begin
      tests++;
      if (st[463 - 32*r -: 32] !== f_reg(r, 0)) begin
        fails++; $display("FAIL nohdr_reg%0d got=%h exp=%h", r, st[463 - 32*r -: 32], f_reg(r, 0));
      end
    end
    tick(1'b0, 1'b1);
    tests++;
    if (s_seq !== 32'd1 || s_valid !== 1'b0) begin
      fails++; $display("FAIL nohdr_seq got=%h vld %b exp=00000001 vld 0", s_seq, s_valid);
    end
    sel_n = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_no_header();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
